// File: rtl/pc_stack_unit_if.sv
// Sequencing strobes, jump operands and PC/return-stack status between control unit and PC stage.
// Latency: none; this is wiring only.
// Backpressure: none; 'en' is the only hold qualifier and is carried here with the strobes.
interface pc_stack_unit_if #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8
);
  localparam int SP_W = $clog2(DEPTH) + 1;

  // Control unit -> PC stage
  logic            en;
  logic            s_inc;
  logic            s_rel;
  logic            swe;
  logic            s_ret;
  logic [PC_W-1:0] jump_addr;
  logic [PC_W-1:0] rel_off;

  // PC stage -> instruction memory / control unit
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            stack_full;
  logic            stack_empty;
  logic            ovf_err;
  logic            unf_err;

  // Control-unit side
  modport master (
    output en, s_inc, s_rel, swe, s_ret, jump_addr, rel_off,
    input  pc, sp, stack_full, stack_empty, ovf_err, unf_err
  );

  // PC-stage side
  modport slave (
    input  en, s_inc, s_rel, swe, s_ret, jump_addr, rel_off,
    output pc, sp, stack_full, stack_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a DEPTH-entry return-address stack; sticky overflow/underflow flags.
// Latency: strobes sampled on a rising edge, new pc/sp visible after that edge (no comb path to pc).
// Backpressure: en=0 freezes pc, sp, stack contents and flags. Optional PCSTACK_TRAP_EN vectors faults to TRAP_ADDR.
module pc_stack_unit #(
  parameter int PC_W      = 10,
  parameter int DEPTH     = 8,
  parameter int TRAP_ADDR = 0
) (
  input  logic           clock,
  input  logic           reset,
  pc_stack_unit_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  // Reject configurations the stack indexing cannot represent.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pc_stack_unit: DEPTH must be a power of two and at least 2");
    end
    if (TRAP_ADDR < 0 || TRAP_ADDR >= (1 << PC_W)) begin : g_bad_trap
      $error("pc_stack_unit: TRAP_ADDR does not fit in PC_W bits");
    end
  endgenerate

  // Architectural state
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_err_q, ovf_err_d;
  logic            unf_err_q, unf_err_d;

  // Return-address storage; contents are meaningless above sp, so it is never reset.
  logic [PC_W-1:0] stack_mem [DEPTH];

  // Write port into the stack, produced by the action decode
  logic             push_vld;
  logic [IDX_W-1:0] push_idx;

  // Address arithmetic, all modulo 2^PC_W
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_rel;
  logic [IDX_W-1:0] top_idx;
  logic [PC_W-1:0]  top_dat;
  logic             stack_full;
  logic             stack_empty;

  // Next pc on a fault: the trap vector when enabled, otherwise the non-fault fallthrough.
  logic [PC_W-1:0]  unf_pc;
  logic [PC_W-1:0]  ovf_pc;

  assign pc_inc      = pc_q + PC_W'(1);
  assign pc_rel      = pc_q + bus.rel_off;
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);

  // sp indexes the next free slot, so the top entry is at sp-1. When sp == DEPTH the
  // low bits wrap to 0 and the decrement lands on DEPTH-1, which is the correct top.
  assign push_idx = sp_q[IDX_W-1:0];
  assign top_idx  = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign top_dat  = stack_mem[top_idx];

`ifdef PCSTACK_TRAP_EN
  localparam logic [PC_W-1:0] TRAP_VEC = PC_W'(TRAP_ADDR);
  assign unf_pc = TRAP_VEC;
  assign ovf_pc = TRAP_VEC;
`else
  // Underflow behaves like a no-op instruction; overflow still takes the call target.
  assign unf_pc = pc_inc;
  assign ovf_pc = bus.jump_addr;
`endif

  // Pick exactly one sequencing action per enabled edge: return, call, relative, absolute, increment.
  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    ovf_err_d = ovf_err_q;
    unf_err_d = unf_err_q;
    push_vld  = 1'b0;

    if (bus.en) begin
      if (bus.s_ret) begin
        // Return beats call when both are strobed: nothing is pushed.
        if (stack_empty) begin
          unf_err_d = 1'b1;
          pc_d      = unf_pc;
        end else begin
          pc_d = top_dat;
          sp_d = sp_q - SP_W'(1);
        end
      end else if (bus.swe) begin
        if (stack_full) begin
          // Stack and sp are left untouched; only the flag records the lost return address.
          ovf_err_d = 1'b1;
          pc_d      = ovf_pc;
        end else begin
          push_vld = 1'b1;
          sp_d     = sp_q + SP_W'(1);
          pc_d     = bus.jump_addr;
        end
      end else if (bus.s_rel) begin
        pc_d = pc_rel;
      end else if (!bus.s_inc) begin
        pc_d = bus.jump_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Register pc, sp and the sticky flags; reset discards any pending return addresses.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= '0;
      sp_q      <= '0;
      ovf_err_q <= 1'b0;
      unf_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      ovf_err_q <= ovf_err_d;
      unf_err_q <= unf_err_d;
    end
  end

  // Push the return address (pc+1 of the calling instruction) into the next free slot.
  always_ff @(posedge clock) begin
    if (push_vld && !reset) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_full  = stack_full;
  assign bus.stack_empty = stack_empty;
  assign bus.ovf_err     = ovf_err_q;
  assign bus.unf_err     = unf_err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed-vector bench for pc_stack_unit with a queue-based scoreboard and a negedge monitor.
// Latency: each vector's expectation is queued at the sampling edge and checked on the next falling edge.
// Backpressure: en=0 vectors expect fully held state.
module tb_pc_stack_unit;

  localparam int PC_W  = 10;
  localparam int DEPTH = 8;

`ifdef PCSTACK_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [PC_W-1:0] TRAP_PC = 10'h200;

  typedef struct packed {
    logic [15:0]     id;
    logic [PC_W-1:0] pc;
    logic [3:0]      sp;
    logic            ovf;
    logic            unf;
  } exp_t;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   step_id;
  exp_t exp_q[$];
  exp_t mx;

  pc_stack_unit_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus();

  pc_stack_unit #(
    .PC_W      (PC_W),
    .DEPTH     (DEPTH),
    .TRAP_ADDR (int'(TRAP_PC))
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] xp);
    n_chk++;
    if (act !== xp) begin
      n_fail++;
      $display("FAIL step%0d %s: got 0x%0h expected 0x%0h", id, nm, act, xp);
    end
  endtask

  // Monitor: the DUT presents a new pc/sp every cycle; compare against the oldest queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      chk("pc",          int'(mx.id), 32'(bus.pc),          32'(mx.pc));
      chk("sp",          int'(mx.id), 32'(bus.sp),          32'(mx.sp));
      chk("stack_full",  int'(mx.id), 32'(bus.stack_full),  32'(mx.sp == 4'(DEPTH)));
      chk("stack_empty", int'(mx.id), 32'(bus.stack_empty), 32'(mx.sp == 4'd0));
      chk("ovf_err",     int'(mx.id), 32'(bus.ovf_err),     32'(mx.ovf));
      chk("unf_err",     int'(mx.id), 32'(bus.unf_err),     32'(mx.unf));
    end
  end

  // Drive one vector, let it be sampled, and queue its hand-computed result.
  task automatic step(input bit rst, input bit e, input bit inc, input bit rel,
                      input bit call, input bit ret,
                      input logic [PC_W-1:0] ja, input logic [PC_W-1:0] ro,
                      input logic [PC_W-1:0] xpc, input int xsp,
                      input bit xovf, input bit xunf);
    exp_t x;
    reset         = rst;
    bus.en        = e;
    bus.s_inc     = inc;
    bus.s_rel     = rel;
    bus.swe       = call;
    bus.s_ret     = ret;
    bus.jump_addr = ja;
    bus.rel_off   = ro;
    @(posedge clock);
    step_id++;
    x.id  = 16'(step_id);
    x.pc  = xpc;
    x.sp  = 4'(xsp);
    x.ovf = xovf;
    x.unf = xunf;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    step_id = 0;

    // Reset state, then sequential fetch
    step(1, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      step(0, 1, 1, 0, 0, 0, 10'h000, 10'h000, 10'(i), 0, 0, 0);

    // Absolute jump, then relative -2 (s_rel beats s_inc=0)
    step(0, 1, 0, 0, 0, 0, 10'h120, 10'h000, 10'h120, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 10'h3AA, 10'h3FE, 10'h11E, 0, 0, 0);

    // Nested calls and returns
    step(0, 1, 0, 0, 0, 0, 10'h010, 10'h000, 10'h010, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 10'h040, 10'h000, 10'h040, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 10'h080, 10'h000, 10'h080, 2, 0, 0);
    step(0, 1, 1, 0, 0, 1, 10'h3FF, 10'h000, 10'h041, 1, 0, 0);
    step(0, 1, 1, 0, 0, 1, 10'h000, 10'h000, 10'h011, 0, 0, 0);

    // DEPTH calls fill the stack (swe beats s_rel); first pushes 0x012, then 0x102..0x108
    for (int k = 1; k <= DEPTH; k++)
      step(0, 1, 1, 1, 1, 0, 10'(10'h100 + k), 10'h005, 10'(10'h100 + k), k, 0, 0);
    // Ninth call overflows
    step(0, 1, 1, 0, 1, 0, 10'h109, 10'h000, TRAP ? TRAP_PC : 10'h109, 8, 1, 0);
    // Unwind: 0x108 down to 0x102, then 0x012
    for (int k = 1; k <= 7; k++)
      step(0, 1, 1, 0, 0, 1, 10'h000, 10'h000, 10'(10'h100 + 9 - k), 8 - k, 1, 0);
    step(0, 1, 1, 0, 0, 1, 10'h000, 10'h000, 10'h012, 0, 1, 0);
    // Ninth return underflows
    step(0, 1, 1, 0, 0, 1, 10'h000, 10'h000, TRAP ? TRAP_PC : 10'h013, 0, 1, 1);

    // Address wrap, push of a wrapped return address, and swe+s_ret together
    step(0, 1, 0, 0, 0, 0, 10'h3FE, 10'h000, 10'h3FE, 0, 1, 1);
    step(0, 1, 1, 0, 1, 0, 10'h3FF, 10'h000, 10'h3FF, 1, 1, 1);
    step(0, 1, 1, 0, 0, 0, 10'h000, 10'h000, 10'h000, 1, 1, 1);
    step(0, 1, 1, 0, 1, 1, 10'h055, 10'h000, 10'h3FF, 0, 1, 1);
    step(0, 1, 1, 0, 1, 0, 10'h030, 10'h000, 10'h030, 1, 1, 1);
    step(0, 1, 1, 0, 0, 1, 10'h000, 10'h000, 10'h000, 0, 1, 1);
    step(0, 1, 1, 1, 0, 0, 10'h000, 10'h3FF, 10'h3FF, 0, 1, 1);

    // en=0 holds everything while strobes are active
    step(0, 1, 1, 0, 1, 0, 10'h077, 10'h000, 10'h077, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 10'h001, 10'h000, 10'h077, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 10'h002, 10'h000, 10'h077, 1, 1, 1);
    step(0, 0, 1, 1, 0, 0, 10'h003, 10'h005, 10'h077, 1, 1, 1);
    step(0, 1, 1, 0, 0, 1, 10'h000, 10'h000, 10'h000, 0, 1, 1);

    // Reset in the middle of a nested call chain
    step(0, 1, 1, 0, 1, 0, 10'h099, 10'h000, 10'h099, 1, 1, 1);
    step(0, 1, 1, 0, 1, 0, 10'h0AA, 10'h000, 10'h0AA, 2, 1, 1);
    step(1, 1, 1, 0, 1, 0, 10'h0BB, 10'h000, 10'h000, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 10'h000, 10'h000, TRAP ? TRAP_PC : 10'h001, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 10'h000, 10'h000, TRAP ? 10'h201 : 10'h002, 0, 0, 1);

    bus.en = 1'b0;
    for (int w = 0; w < 5 && exp_q.size() > 0; w++)
      @(posedge clock);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
